// File: rtl/tmds_encoder_multi.sv
// Multi-channel TMDS/TERC4 encoder for the HDMI transmit path.
// Two-stage pipeline: transition minimisation, then DC balance / symbol select.
module tmds_encoder_multi #(
  parameter int CHANNELS               = 3,
  parameter int LEGACY_DVI_CONTROL_LUT = 0,
  parameter int CNT_WIDTH              = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [2:0]              mode,
  input  logic [8*CHANNELS-1:0]   d,
  input  logic [2*CHANNELS-1:0]   c,
  input  logic [4*CHANNELS-1:0]   terc4,
  output logic                    out_valid,
  output logic [10*CHANNELS-1:0]  q_out
);

  typedef enum logic [2:0] {
    MODE_CONTROL = 3'd0,
    MODE_VIDEO   = 3'd1,
    MODE_VGUARD  = 3'd2,
    MODE_DATA    = 3'd3,
    MODE_DGUARD  = 3'd4
  } mode_e;

  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;
  localparam logic signed [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

  function automatic logic [9:0] ctrl_sym(input logic [1:0] cc);
    logic [9:0] s;
    if (LEGACY_DVI_CONTROL_LUT != 0) begin
      case (cc)
        2'b00:   s = 10'b0010101011;
        2'b01:   s = 10'b1101010100;
        2'b10:   s = 10'b0010101010;
        default: s = 10'b1101010101;
      endcase
    end else begin
      case (cc)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
    end
    return s;
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] t);
    logic [9:0] s;
    case (t)
      4'd0:    s = 10'b1010011100;
      4'd1:    s = 10'b1001100011;
      4'd2:    s = 10'b1011100100;
      4'd3:    s = 10'b1011100010;
      4'd4:    s = 10'b0101110001;
      4'd5:    s = 10'b0100011110;
      4'd6:    s = 10'b0110001110;
      4'd7:    s = 10'b0100111100;
      4'd8:    s = 10'b1011001100;
      4'd9:    s = 10'b0100111001;
      4'd10:   s = 10'b0110011100;
      4'd11:   s = 10'b1011000110;
      4'd12:   s = 10'b1010001110;
      4'd13:   s = 10'b1001110001;
      4'd14:   s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  mode_e r_mode;
  logic  r_s1_valid;
  logic  r_out_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode      <= MODE_CONTROL;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid  <= in_valid;
      r_out_valid <= r_s1_valid;
      if (in_valid) r_mode <= mode_e'(mode);
    end
  end

  assign out_valid = r_out_valid;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0]                  w_d;
    logic [8:0]                  w_qm;
    logic [8:0]                  r_qm;
    logic [3:0]                  r_n1;
    logic [1:0]                  r_c;
    logic [3:0]                  r_t;
    logic [9:0]                  r_sym;
    logic signed [CNT_WIDTH-1:0] r_cnt;
    logic [9:0]                  w_sym;
    logic signed [CNT_WIDTH-1:0] w_cnt_nxt;
    logic signed [CNT_WIDTH-1:0] w_diff;
    logic                        w_q8;

    assign w_d = d[8*i +: 8];

    always_comb begin
      logic [3:0] v_n1d;
      logic       v_xnor;
      logic [8:0] v_qm;
      v_n1d   = ones8(w_d);
      v_xnor  = (v_n1d > 4'd4) || ((v_n1d == 4'd4) && !w_d[0]);
      v_qm    = '0;
      v_qm[0] = w_d[0];
      for (int unsigned b = 1; b < 8; b++)
        v_qm[b] = v_xnor ? ~(v_qm[b-1] ^ w_d[b]) : (v_qm[b-1] ^ w_d[b]);
      v_qm[8] = ~v_xnor;
      w_qm    = v_qm;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_qm <= '0;
        r_n1 <= '0;
        r_c  <= '0;
        r_t  <= '0;
      end else if (in_valid) begin
        r_qm <= w_qm;
        r_n1 <= ones8(w_qm[7:0]);
        r_c  <= c[2*i +: 2];
        r_t  <= terc4[4*i +: 4];
      end
    end

    // w_diff is N1-N0 of q_m[7:0], i.e. 2*N1-8
    assign w_diff = $signed(CNT_WIDTH'({r_n1, 1'b0}) - CNT_WIDTH'(8));
    assign w_q8   = r_qm[8];

    always_comb begin
      w_sym     = ctrl_sym(r_c);
      w_cnt_nxt = '0;
      case (r_mode)
        MODE_VIDEO: begin
          if ((r_cnt == '0) || (r_n1 == 4'd4)) begin
            w_sym     = {~w_q8, w_q8, w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
          end else if ((!r_cnt[CNT_WIDTH-1] && (r_n1 > 4'd4)) ||
                       ( r_cnt[CNT_WIDTH-1] && (r_n1 < 4'd4))) begin
            w_sym     = {1'b1, w_q8, ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (w_q8 ? TWO : '0) - w_diff;
          end else begin
            w_sym     = {1'b0, w_q8, r_qm[7:0]};
            w_cnt_nxt = r_cnt - (w_q8 ? '0 : TWO) + w_diff;
          end
        end
        MODE_VGUARD: w_sym = ((i % 3) == 1) ? GUARD_B : GUARD_A;
        MODE_DATA:   w_sym = terc4_sym(r_t);
        MODE_DGUARD: w_sym = (i == 0) ? terc4_sym(r_t) : GUARD_B;
        default:     w_sym = ctrl_sym(r_c);
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_sym <= ctrl_sym(2'b00);
        r_cnt <= '0;
      end else if (r_s1_valid) begin
        r_sym <= w_sym;
        r_cnt <= w_cnt_nxt;
      end
    end

    assign q_out[10*i +: 10] = r_sym;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Scoreboard bench for tmds_encoder_multi: HDMI-LUT and DVI-LUT instances driven in lockstep.
module tb_tmds_encoder_multi;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [23:0] d = '0;
  logic [5:0]  c = '0;
  logic [11:0] terc4 = '0;
  logic        ov0, ov1;
  logic [29:0] q0, q1;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp0_q[$];
  logic [29:0] exp1_q[$];
  logic [29:0] e0_m, e1_m;
  int mcnt[3];

  localparam logic [9:0] GA = 10'b1011001100;
  localparam logic [9:0] GB = 10'b0100110011;
  localparam logic [9:0] V0 = 10'b0100000000;
  localparam logic [9:0] V1 = 10'b1111111111;

  logic [9:0] TERC[16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                           10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                           10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                           10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  logic [9:0] CTL_H[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] CTL_D[4] = '{10'b0010101011, 10'b1101010100, 10'b0010101010, 10'b1101010101};

  always #5 clk = ~clk;

  tmds_encoder_multi #(.CHANNELS(3), .LEGACY_DVI_CONTROL_LUT(0), .CNT_WIDTH(6)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .mode(mode), .d(d), .c(c),
    .terc4(terc4), .out_valid(ov0), .q_out(q0));

  tmds_encoder_multi #(.CHANNELS(3), .LEGACY_DVI_CONTROL_LUT(1), .CNT_WIDTH(6)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .mode(mode), .d(d), .c(c),
    .terc4(terc4), .out_valid(ov1), .q_out(q1));

  // Scoreboard: pop one expectation per valid output symbol.
  always @(negedge clk) begin
    if (resetn && ov0) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL sb_hdmi_unexpected got=%b expected=no output", q0);
      end else begin
        e0_m = exp0_q.pop_front();
        if (q0 !== e0_m) begin
          errors++;
          $display("FAIL sb_hdmi got=%b expected=%b", q0, e0_m);
        end
      end
    end
    if (resetn && ov1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL sb_dvi_unexpected got=%b expected=no output", q1);
      end else begin
        e1_m = exp1_q.pop_front();
        if (q1 !== e1_m) begin
          errors++;
          $display("FAIL sb_dvi got=%b expected=%b", q1, e1_m);
        end
      end
    end
  end

  function automatic logic [9:0] tmds_video(input logic [7:0] dv, input int cin, output int cout);
    int n1d, n1, n0;
    logic [7:0] qm;
    logic use_xnor, q8;
    n1d = $countones(dv);
    use_xnor = (n1d > 4) || (n1d == 4 && dv[0] == 1'b0);
    qm[0] = dv[0];
    for (int b = 1; b < 8; b++) qm[b] = use_xnor ? (qm[b-1] ~^ dv[b]) : (qm[b-1] ^ dv[b]);
    q8 = !use_xnor;
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      if (q8) begin cout = cin + n1 - n0; return {2'b01, qm}; end
      else    begin cout = cin + n0 - n1; return {2'b10, ~qm}; end
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      cout = cin + (q8 ? 2 : 0) + n0 - n1;
      return {1'b1, q8, ~qm};
    end else begin
      cout = cin - (q8 ? 0 : 2) + n1 - n0;
      return {1'b0, q8, qm};
    end
  endfunction

  task automatic send(input logic [2:0] m, input logic [23:0] dd, input logic [5:0] cc,
                      input logic [11:0] tt, input logic [29:0] e0, input logic [29:0] e1);
    @(negedge clk);
    mode = m; d = dd; c = cc; terc4 = tt; in_valid = 1'b1;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    in_valid = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    for (int l = 0; l < 3; l++) mcnt[l] = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0 || q0 !== {3{CTL_H[0]}} || q1 !== {3{CTL_D[0]}}) begin
        errors++;
        $display("FAIL reset_pulse got ov=%b/%b q=%b/%b expected ov=0/0 q=%b/%b",
                 ov0, ov1, q0, q1, {3{CTL_H[0]}}, {3{CTL_D[0]}});
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || q0 !== {3{CTL_H[0]}} || q1 !== {3{CTL_D[0]}}) begin
      errors++;
      $display("FAIL reset_hold got ov=%b q=%b/%b expected ov=0 q=%b/%b",
               ov0, q0, q1, {3{CTL_H[0]}}, {3{CTL_D[0]}});
    end
    @(posedge clk);
    #2;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0 || q0 !== {3{CTL_H[0]}}) begin
        errors++;
        $display("FAIL reset_idle got ov=%b/%b q=%b expected ov=0/0 q=%b",
                 ov0, ov1, q0, {3{CTL_H[0]}});
      end
    end
  endtask

  task automatic test_video_zero();
    send(3'd1, 24'h000000, 6'd0, 12'd0, {3{V0}}, {3{V0}});
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got out_valid=%b expected 0", ov0);
    end
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1) begin
      errors++;
      $display("FAIL latency_due got out_valid=%b expected 1", ov0);
    end
    send(3'd1, 24'h000000, 6'd0, 12'd0, {3{V1}}, {3{V1}});
    repeat (4) idle();
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || q0 !== {3{V1}}) begin
      errors++;
      $display("FAIL bubble_hold got ov=%b q=%b expected ov=0 q=%b", ov0, q0, {3{V1}});
    end
  endtask

  task automatic test_control();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] cc;
      cc = 2'(k);
      send(3'd0, 24'hA5A5A5, {3{cc}}, 12'd0, {3{CTL_H[k]}}, {3{CTL_D[k]}});
    end
    for (int m = 5; m < 8; m++)
      send(3'(m), 24'h123456, 6'b00_01_10, 12'd0,
           {CTL_H[0], CTL_H[1], CTL_H[2]}, {CTL_D[0], CTL_D[1], CTL_D[2]});
  endtask

  task automatic test_guard();
    send(3'd2, 24'hFFFFFF, 6'b111111, 12'hFFF, {GA, GB, GA}, {GA, GB, GA});
    send(3'd4, 24'h000000, 6'd0, {4'h5, 4'h5, 4'hC}, {GB, GB, TERC[12]}, {GB, GB, TERC[12]});
  endtask

  task automatic test_data_island();
    send(3'd1, 24'h000000, 6'd0, 12'd0, {3{V0}}, {3{V0}});
    for (int n = 0; n < 16; n++) begin
      logic [3:0] t;
      t = 4'(n);
      send(3'd3, 24'h000000, 6'd0, {3{t}}, {3{TERC[n]}}, {3{TERC[n]}});
    end
    send(3'd1, 24'h000000, 6'd0, 12'd0, {3{V0}}, {3{V0}});
  endtask

  task automatic test_random_video();
    reset_pulse();
    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [23:0] dd;
      logic [29:0] e;
      int nc;
      if (n == 150) reset_pulse();
      r = $urandom_range(0, 9);
      dd = 24'($urandom());
      if (r < 2) begin
        idle();
      end else if (r == 2) begin
        logic [5:0] cc;
        logic [29:0] eh, ed;
        cc = 6'($urandom());
        for (int l = 0; l < 3; l++) begin
          eh[10*l +: 10] = CTL_H[cc[2*l +: 2]];
          ed[10*l +: 10] = CTL_D[cc[2*l +: 2]];
          mcnt[l] = 0;
        end
        send(3'd0, dd, cc, 12'd0, eh, ed);
      end else begin
        for (int l = 0; l < 3; l++) begin
          e[10*l +: 10] = tmds_video(dd[8*l +: 8], mcnt[l], nc);
          mcnt[l] = nc;
        end
        send(3'd1, dd, 6'd0, 12'd0, e, e);
      end
    end
  endtask

  task automatic test_drain();
    repeat (4) idle();
    @(negedge clk);
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d expected 0/0", exp0_q.size(), exp1_q.size());
    end
  endtask

  initial begin
    for (int l = 0; l < 3; l++) mcnt[l] = 0;
    test_reset();
    test_video_zero();
    test_control();
    test_guard();
    test_data_island();
    test_drain();
    test_random_video();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
